// File: rtl/ecap5_dwbuart_pkg.sv
// ----------------------------------------------------------------------------
// ecap5_dwbuart_pkg
//   Types and helpers shared by the UART transmit and receive paths.
//   - uart_state_t : frame sequencing states
//   - parity_t     : cr_p encodings (00/11 none, 01 even, 10 odd)
//   - DIV_W        : width of the bit-period divider
//   - parity_enabled() / reload_value() : decode helpers
// ----------------------------------------------------------------------------
package ecap5_dwbuart_pkg;

    localparam int unsigned DIV_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } uart_state_t;

    typedef enum logic [1:0] {
        PARITY_NONE     = 2'b00,
        PARITY_EVEN     = 2'b01,
        PARITY_ODD      = 2'b10,
        PARITY_NONE_ALT = 2'b11
    } parity_t;

    function automatic logic parity_enabled(input parity_t p);
        return (p == PARITY_EVEN) || (p == PARITY_ODD);
    endfunction

    // A divider of 0 or 1 both mean a one-cycle bit, so the down-counter
    // reloads with max(div,1)-1 and the bit ends when it reaches zero.
    function automatic logic [DIV_W-1:0] reload_value(input logic [DIV_W-1:0] div);
        return (div <= 16'd1) ? '0 : div - 16'd1;
    endfunction

endpackage

// File: rtl/tx_frontend_if.sv
// ----------------------------------------------------------------------------
// tx_frontend_if
//   Byte-input handshake of the UART transmitter.
//   data_i        : byte to send (LSB first)
//   input_valid_i : data_i valid (driven by the producer)
//   input_ready_o : transmitter can accept a byte (driven by tx_frontend)
//   master = producer side, slave = tx_frontend side.
// ----------------------------------------------------------------------------
interface tx_frontend_if;
    logic [7:0] data_i;
    logic       input_valid_i;
    logic       input_ready_o;

    modport master (output data_i, output input_valid_i, input  input_ready_o);
    modport slave  (input  data_i, input  input_valid_i, output input_ready_o);
endinterface

// File: rtl/tx_frontend_baud_gen.sv
// ----------------------------------------------------------------------------
// baud_gen
//   Bit-period timer: 16-bit down-counter reloaded with max(div,1)-1 on load.
//   clk_i : clock           rst_i : async reset, active-low
//   load  : reload at a bit boundary (or frame start)
//   div   : bit period in clk_i cycles
//   tick  : counter at zero -- the current bit ends on this cycle's edge
// ----------------------------------------------------------------------------
module baud_gen
    import ecap5_dwbuart_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= reload_value(div);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/tx_frontend.sv
// ----------------------------------------------------------------------------
// tx_frontend
//   UART transmitter: serialises one byte per handshake as
//   START, 7/8 DATA bits (LSB first), optional PARITY, one or two STOP bits.
//   clk_i        : clock                 rst_i     : async reset, active-low
//   cr_clk_div_i : bit period (0,1 -> 1) cr_ds_i   : 0 = 8 bits, 1 = 7 bits
//   cr_p_i       : parity (parity_t)     cr_s_i    : 0 = 1 stop, 1 = 2 stop
//   in_if        : data_i / input_valid_i / input_ready_o handshake
//   uart_tx_o    : registered serial line, idle high
// ----------------------------------------------------------------------------
module tx_frontend
    import ecap5_dwbuart_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] cr_clk_div_i,
    input  logic             cr_ds_i,
    input  logic [1:0]       cr_p_i,
    input  logic             cr_s_i,
    tx_frontend_if.slave     in_if,
    output logic             uart_tx_o
);

    uart_state_t      state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             tx_d;

    // Frame configuration captured at acceptance.
    logic [DIV_W-1:0] div_q;
    logic             ds_q;
    parity_t          p_q;
    logic             s_q;
    logic             par_q;

    logic             accept;
    logic             load;
    logic             tick;
    logic [DIV_W-1:0] div_sel;
    logic [7:0]       data_masked;

    assign in_if.input_ready_o = (state_q == IDLE);
    assign accept              = (state_q == IDLE) && in_if.input_valid_i;

    // The first bit period must use the live divider because div_q only
    // captures it on the accepting edge.
    assign div_sel     = (state_q == IDLE) ? cr_clk_div_i : div_q;
    assign data_masked = cr_ds_i ? {1'b0, in_if.data_i[6:0]} : in_if.data_i;

    baud_gen u_baud_gen (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .load  (load),
        .div   (div_sel),
        .tick  (tick)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            uart_tx_o <= 1'b1;
            div_q     <= '0;
            ds_q      <= 1'b0;
            p_q       <= PARITY_NONE;
            s_q       <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            uart_tx_o <= tx_d;
            if (accept) begin
                div_q <= cr_clk_div_i;
                ds_q  <= cr_ds_i;
                p_q   <= parity_t'(cr_p_i);
                s_q   <= cr_s_i;
                par_q <= (^data_masked) ^ (cr_p_i == PARITY_ODD);
            end
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_if.input_valid_i) begin
                    state_d   = START;
                    shift_d   = in_if.data_i;
                    bit_cnt_d = '0;
                    load      = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    load    = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    load = 1'b1;
                    if (bit_cnt_q == (ds_q ? 3'd6 : 3'd7)) begin
                        state_d = parity_enabled(p_q) ? PARITY : STOP1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP1;
                    load    = 1'b1;
                end
            end
            STOP1: begin
                if (tick) begin
                    state_d = s_q ? STOP2 : IDLE;
                    load    = s_q;
                end
            end
            STOP2: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is registered: it shows the level of the state entered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_tx_frontend.sv
// ----------------------------------------------------------------------------
// tb_tx_frontend
//   Randomised and directed frames against a frame-level reference model.
//   On each acceptance the model pushes the expected per-cycle line levels
//   into a queue; an independent monitor pops one level per cycle.
// ----------------------------------------------------------------------------
module tb_tx_frontend;
    import ecap5_dwbuart_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] cr_clk_div;
    logic        cr_ds;
    logic [1:0]  cr_p;
    logic        cr_s;
    logic        uart_tx;

    tx_frontend_if bus ();

    tx_frontend dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .cr_clk_div_i (cr_clk_div),
        .cr_ds_i      (cr_ds),
        .cr_p_i       (cr_p),
        .cr_s_i       (cr_s),
        .in_if        (bus),
        .uart_tx_o    (uart_tx)
    );

    int n_checks = 0;
    int n_err    = 0;

    bit exp_q[$];
    int busy       = 0;
    int accept_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference: a frame is a list of bits, each held max(div,1) cycles.
    function automatic int build_frame(input logic [7:0] d, input logic [15:0] div,
                                       input logic ds, input logic [1:0] p, input logic s);
        bit bits[$];
        bit ones;
        int n;
        int period;
        n      = ds ? 7 : 8;
        period = (div == 0) ? 1 : int'(div);
        ones   = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(d[i]);
            ones ^= d[i];
        end
        if (p == 2'b01) bits.push_back(ones);
        if (p == 2'b10) bits.push_back(!ones);
        bits.push_back(1'b1);
        if (s) bits.push_back(1'b1);
        foreach (bits[k])
            for (int c = 0; c < period; c++) exp_q.push_back(bits[k]);
        return bits.size() * period;
    endfunction

    // Model: busy for the whole frame length, inputs sampled only when idle.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                busy = 0;
                exp_q.delete();
            end else if (busy > 0) begin
                busy--;
            end else if (bus.input_valid_i === 1'b1) begin
                busy = build_frame(bus.data_i, cr_clk_div, cr_ds, cr_p, cr_s);
                accept_cnt++;
            end
        end
    end

    // Monitor: one expected line level and ready value per cycle.
    initial begin
        bit exp_tx;
        forever begin
            @(negedge clk);
            exp_tx = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            check("uart_tx", uart_tx, exp_tx);
            check("input_ready", bus.input_ready_o, busy == 0);
        end
    end

    task automatic wait_accept(input int start_cnt);
        int t;
        t = 0;
        while (accept_cnt == start_cnt && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (accept_cnt == start_cnt) timeout_fail("accept");
    endtask

    task automatic send(input logic [7:0] d, input logic [15:0] div, input logic ds,
                        input logic [1:0] p, input logic s, input bit hold);
        int start_cnt;
        @(negedge clk);
        bus.data_i        = d;
        cr_clk_div        = div;
        cr_ds             = ds;
        cr_p              = p;
        cr_s              = s;
        bus.input_valid_i = 1'b1;
        start_cnt         = accept_cnt;
        wait_accept(start_cnt);
        if (!hold) bus.input_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((busy != 0 || exp_q.size() != 0) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (busy != 0 || exp_q.size() != 0) timeout_fail("frame_done");
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cnt;
        rst_n             = 1'b0;
        bus.data_i        = 8'h00;
        bus.input_valid_i = 1'b0;
        cr_clk_div        = 16'd1;
        cr_ds             = 1'b0;
        cr_p              = 2'b00;
        cr_s              = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_tx", uart_tx, 1'b1);
        check("reset_ready", bus.input_ready_o, 1'b1);
        check("reset_state", dut.state_q, IDLE);
        #2 rst_n = 1'b1;

        // 8N1 div=4 0x55
        send(8'h55, 16'd4, 1'b0, 2'b00, 1'b0, 1'b0);
        wait_idle();
        // 8E1 / 8O1 div=2 0x03
        send(8'h03, 16'd2, 1'b0, 2'b01, 1'b0, 1'b0);
        wait_idle();
        send(8'h03, 16'd2, 1'b0, 2'b10, 1'b0, 1'b0);
        wait_idle();
        // 7O2 div=3 0xC1
        send(8'hC1, 16'd3, 1'b1, 2'b10, 1'b1, 1'b0);
        wait_idle();
        // div=0 behaves as div=1
        send(8'h96, 16'd0, 1'b0, 2'b11, 1'b1, 1'b0);
        wait_idle();

        // Inputs changed and valid pulsed mid-frame
        send(8'h3C, 16'd3, 1'b0, 2'b01, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        cr_p              = 2'b10;
        cr_clk_div        = 16'd7;
        cr_ds             = 1'b1;
        cr_s              = 1'b1;
        bus.data_i        = 8'hFF;
        bus.input_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.input_valid_i = 1'b0;
        wait_idle();

        // Back-to-back with valid held: 0x0F then 0xF0, 8N1 div=1
        send(8'h0F, 16'd1, 1'b0, 2'b00, 1'b0, 1'b1);
        bus.data_i = 8'hF0;
        start_cnt  = accept_cnt;
        wait_accept(start_cnt);
        bus.input_valid_i = 1'b0;
        wait_idle();

        // Reset during DATA bit 3, div=8 (cycle 35 after acceptance)
        send(8'h5A, 16'd8, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (34) @(negedge clk);
        check("pre_reset_state", dut.state_q, DATA);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_tx", uart_tx, 1'b1);
        check("async_reset_state", dut.state_q, IDLE);
        check("async_reset_ready", bus.input_ready_o, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        send(8'hA5, 16'd2, 1'b0, 2'b00, 1'b0, 1'b0);
        wait_idle();

        // Random frames, with inputs scrambled while each frame is in flight
        for (int i = 0; i < 40; i++) begin
            send(8'($urandom), 16'($urandom_range(0, 4)), 1'($urandom),
                 2'($urandom), 1'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                bus.data_i = 8'($urandom);
                cr_clk_div = 16'($urandom_range(0, 9));
                cr_ds      = 1'($urandom);
                cr_p       = 2'($urandom);
                cr_s       = 1'($urandom);
            end
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/tx_frontend.md
TX_FRONTEND -- requirements
Module: tx_frontend

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are named as below.
REQ-002 clk_i  in  1  system clock; all state updates on rising edge.
REQ-003 rst_i  in  1  asynchronous reset, active-low.
REQ-004 cr_clk_div_i  in  16  bit period in clk_i cycles; values 0 and 1 both mean 1 cycle.
REQ-005 cr_ds_i  in  1  data size: 0 = 8 data bits, 1 = 7 data bits.
REQ-006 cr_p_i  in  2  parity: 00 none, 01 even, 10 odd, 11 none.
REQ-007 cr_s_i  in  1  stop bits: 0 = one, 1 = two.
REQ-008 data_i  in  8  byte to send, LSB first; bit 7 is ignored when cr_ds_i=1.
REQ-009 input_valid_i  in  1  data_i valid.
REQ-010 input_ready_o  out  1  block can accept a byte.
REQ-011 uart_tx_o  out  1  serial line; idle high.

Function
REQ-012 A byte SHALL be accepted on a rising edge where input_valid_i and input_ready_o are both 1.
REQ-013 input_ready_o SHALL be 1 only in IDLE.
REQ-014 input_valid_i SHALL be ignored while input_ready_o=0.
REQ-015 At acceptance, data_i, cr_clk_div_i, cr_ds_i, cr_p_i and cr_s_i SHALL be latched; later changes to these inputs SHALL NOT affect the frame in flight.
REQ-016 States SHALL be: IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-017 IDLE->START on acceptance.
REQ-018 START->DATA after one bit period.
REQ-019 DATA SHALL last 8 or 7 bit periods, then go to PARITY if parity is enabled, else to STOP1.
REQ-020 PARITY->STOP1 after one bit period.
REQ-021 STOP1 SHALL go to STOP2 if cr_s_i=1, else to IDLE, after one bit period.
REQ-022 STOP2->IDLE after one bit period.
REQ-023 uart_tx_o SHALL be registered and SHALL take these values: 1 in IDLE; 0 in START; the current data bit in DATA (LSB first); the parity bit in PARITY; 1 in STOP1 and STOP2.
REQ-024 uart_tx_o SHALL fall to 0 on the first rising edge after acceptance, i.e. 1 cycle of latency.
REQ-025 Each bit SHALL hold for exactly max(cr_clk_div_i,1) cycles, timed by a 16-bit down-counter reloaded at every bit boundary.
REQ-026 Even parity bit SHALL be the XOR of the transmitted data bits; odd parity bit SHALL be its inverse; only 7 bits are used when cr_ds_i=1.
REQ-027 Frame length SHALL be (1 + N + P + S) bit periods, where N is 7 or 8, P is 0 or 1, and S is 1 or 2.
REQ-028 After the last stop bit the block SHALL spend at least one cycle in IDLE with input_ready_o=1 before the next START.
REQ-029 Back-to-back frames with input_valid_i held high SHALL therefore be separated by exactly one idle-high cycle.

Reset
REQ-030 When rst_i=0, the block SHALL immediately and asynchronously enter IDLE, drive uart_tx_o=1 and input_ready_o=1, and clear the bit counter, the cycle counter and the shift register.
REQ-031 A reset asserted mid-frame SHALL abort the frame without emitting any further bits.
REQ-032 After rst_i returns to 1, the first acceptance SHALL start a clean frame.

Structure
REQ-033 The state enumeration and the parity encodings (NONE/EVEN/ODD) SHALL live in the shared ecap5_dwbuart_pkg, so they are common with the receive path.
REQ-034 The state register SHALL be named state_q and SHALL be exposed to the bench through the Verilator public configuration.
REQ-035 The bit-period counter MAY be a sub-module named baud_gen (inputs: load and div; output: tick); otherwise the block SHALL be a single module.

Verification
REQ-036 8N1, div=4, data 0x55, one accept -> uart_tx_o = 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total), LSB first; input_ready_o high again on cycle 41.
REQ-037 8E1, div=2, data 0x03 -> parity bit 0, 11 bits, 22 cycles; then 8O1 with the same data -> parity bit 1.
REQ-038 7O2, div=3, data 0xC1 -> 7 data bits 1,0,0,0,0,0,1, parity bit 1, two stop bits; 11 bits, 33 cycles; bit 7 of data_i never appears on the line.
REQ-039 Change cr_p_i, cr_clk_div_i and data_i mid-frame, and pulse input_valid_i while busy -> the frame is unaltered and no second frame starts.
REQ-040 Assert rst_i=0 during DATA bit 3, div=8 -> uart_tx_o=1 and state_q=IDLE without waiting for a clock edge; after release, a new 0xA5 8N1 frame is bit-exact.
REQ-041 Hold input_valid_i high across two frames (0x0F then 0xF0, 8N1, div=1) -> 10 bits, 1 idle-high cycle, 10 bits.
